// File: rtl/uart_cmd_host_if.sv
// uart_cmd_host_if: command-side and UART-side handshake bundle for uart_cmd_host.
//   BurstLength : response bytes per read; sets the o_rsp_data width (8*BurstLength).
//   slave modport  : seen by uart_cmd_host (takes commands, drives the UART).
//   master modport : seen by the requester and the UART model.
//   cmd   : i_cmd_valid/o_cmd_rdy handshake, i_cmd_wr, i_cmd_addr, i_cmd_data
//   rsp   : o_wr_done, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_stray
//   uart  : o_tx_data/o_tx_req/i_tx_rdy, i_rx_data/i_rx_rdy/o_rx_req
interface uart_cmd_host_if #(
  parameter int BurstLength = 4
);
  logic                     i_cmd_valid;
  logic                     o_cmd_rdy;
  logic                     i_cmd_wr;
  logic [7:0]               i_cmd_addr;
  logic [7:0]               i_cmd_data;
  logic                     o_wr_done;
  logic                     o_rsp_valid;
  logic [8*BurstLength-1:0] o_rsp_data;
  logic                     o_rsp_timeout;
  logic                     o_stray;
  logic [7:0]               o_tx_data;
  logic                     o_tx_req;
  logic                     i_tx_rdy;
  logic [7:0]               i_rx_data;
  logic                     i_rx_rdy;
  logic                     o_rx_req;

  modport slave (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data, i_tx_rdy, i_rx_data, i_rx_rdy,
    output o_cmd_rdy, o_wr_done, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_stray,
           o_tx_data, o_tx_req, o_rx_req
  );

  modport master (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data, i_tx_rdy, i_rx_data, i_rx_rdy,
    input  o_cmd_rdy, o_wr_done, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_stray,
           o_tx_data, o_tx_req, o_rx_req
  );
endinterface

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side initiator for the SDRAM test command protocol over UART.
// Write sends 0x77, addr, data; read sends 0x72, addr and then collects BurstLength
// response bytes into one parallel word (byte i at bits [8i+7:8i]).
//   dram_clk : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : uart_cmd_host_if.slave (command, response and UART handshakes)
// Optional feature: define UART_CMD_HOST_TIMEOUT_EN to enable the read timeout
// (TimeoutCycles = (ClockFreq/BaudRate)*10*TimeoutBytes); otherwise RX_WAIT waits forever
// and o_rsp_timeout stays 0.
module uart_cmd_host #(
  parameter int BurstLength  = 4,
  parameter int ClockFreq    = 100_000_000,
  parameter int BaudRate     = 115200,
  parameter int TimeoutBytes = 8
) (
  input logic           dram_clk,
  input logic           i_rst_n,
  uart_cmd_host_if.slave bus
);
  localparam int RxW           = $clog2(BurstLength + 1);
  localparam int TimeoutCycles = (ClockFreq / BaudRate) * 10 * TimeoutBytes;

  if (BurstLength < 1 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("uart_cmd_host: BurstLength and TimeoutCycles must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, TX_REQ, TX_GUARD, TX_DONE, RX_WAIT} state_e;

  state_e                        state_q, state_d;
  logic [2:0][7:0]               buf_q, buf_d;       // [0]=opcode [1]=addr [2]=data
  logic                          wr_q, wr_d;
  logic [1:0]                    byte_cnt_q, byte_cnt_d;
  logic                          guard_q, guard_d;
  logic [RxW-1:0]                rx_cnt_q, rx_cnt_d;
  logic [BurstLength-1:0][7:0]   rx_buf_q, rx_buf_d; // bytes of the read in flight
  logic [BurstLength-1:0][7:0]   rsp_q, rsp_d;       // last completed response
  logic                          cmd_rdy_q, cmd_rdy_d;
  logic                          rx_req_q, rx_req_d;
  logic                          stray_q, stray_d;
  logic                          tx_req_c, wr_done_c, rsp_valid_c, rsp_tmo_c;
  logic                          rx_take, last_byte, tmo_hit;

  // A pending ack blocks a second take of the same byte.
  assign rx_take   = bus.i_rx_rdy && !rx_req_q;
  assign last_byte = (byte_cnt_q == (wr_q ? 2'd2 : 2'd1));

`ifdef UART_CMD_HOST_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  // Counts idle RX_WAIT cycles; any stored byte restarts it (byte beats expiry).
  assign tmo_d   = (state_q == RX_WAIT && !rx_take) ? tmo_q + TmoW'(1) : '0;
  assign tmo_hit = (tmo_q == TmoW'(TimeoutCycles - 1));
  always_ff @(posedge dram_clk) begin
    if (!i_rst_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge dram_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      wr_q       <= 1'b0;
      byte_cnt_q <= '0;
      guard_q    <= 1'b0;
      rx_cnt_q   <= '0;
      rx_buf_q   <= '0;
      rsp_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      rx_req_q   <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wr_q       <= wr_d;
      byte_cnt_q <= byte_cnt_d;
      guard_q    <= guard_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      rsp_q      <= rsp_d;
      cmd_rdy_q  <= cmd_rdy_d;
      rx_req_q   <= rx_req_d;
      stray_q    <= stray_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wr_d        = wr_q;
    byte_cnt_d  = byte_cnt_q;
    guard_d     = guard_q;
    rx_cnt_d    = rx_cnt_q;
    rx_buf_d    = rx_buf_q;
    rsp_d       = rsp_q;
    tx_req_c    = 1'b0;
    wr_done_c   = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_tmo_c   = 1'b0;
    // Every available byte is acked; outside RX_WAIT it is dropped as stray.
    rx_req_d    = rx_take;
    stray_d     = rx_take && (state_q != RX_WAIT);
    case (state_q)
      IDLE: begin
        if (bus.i_cmd_valid && cmd_rdy_q) begin
          buf_d      = {bus.i_cmd_data, bus.i_cmd_addr, (bus.i_cmd_wr ? 8'h77 : 8'h72)};
          wr_d       = bus.i_cmd_wr;
          byte_cnt_d = '0;
          state_d    = TX_REQ;
        end
      end
      TX_REQ: begin
        if (bus.i_tx_rdy) begin
          tx_req_c = 1'b1;
          guard_d  = 1'b0;
          state_d  = TX_GUARD;
        end
      end
      TX_GUARD: begin
        // Two cycles so the UART has time to drop tx_rdy for the byte just sent.
        guard_d = 1'b1;
        if (guard_q) state_d = TX_DONE;
      end
      TX_DONE: begin
        if (bus.i_tx_rdy) begin
          if (!last_byte) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = TX_REQ;
          end else if (wr_q) begin
            wr_done_c = 1'b1;
            state_d   = IDLE;
          end else begin
            rx_cnt_d = '0;
            state_d  = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (rx_cnt_q == RxW'(BurstLength)) begin
          rsp_valid_c = 1'b1;
          state_d     = IDLE;
        end else if (rx_take) begin
          for (int i = 0; i < BurstLength; i++)
            if (rx_cnt_q == RxW'(i)) rx_buf_d[i] = bus.i_rx_data;
          rx_cnt_d = rx_cnt_q + RxW'(1);
          // Publish on the last store so data is stable in the o_rsp_valid cycle.
          if (rx_cnt_q == RxW'(BurstLength - 1)) rsp_d = rx_buf_d;
        end else if (tmo_hit) begin
          rsp_tmo_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready follows the state being entered, so it rises the cycle after a done pulse.
  assign cmd_rdy_d = (state_d == IDLE);

  // Mealy pulses are masked in reset so an aborted transaction emits nothing.
  assign bus.o_cmd_rdy     = cmd_rdy_q;
  assign bus.o_tx_req      = tx_req_c & i_rst_n;
  assign bus.o_tx_data     = bus.o_tx_req ? buf_q[byte_cnt_q] : 8'h00;
  assign bus.o_wr_done     = wr_done_c & i_rst_n;
  assign bus.o_rsp_valid   = rsp_valid_c & i_rst_n;
  assign bus.o_rsp_timeout = rsp_tmo_c & i_rst_n;
  assign bus.o_rsp_data    = rsp_q;
  assign bus.o_rx_req      = rx_req_q;
  assign bus.o_stray       = stray_q;
endmodule
